// File: rtl/avg_unpool.sv
// Streaming 2x nearest-neighbour unpooling: captures one 4x4 quadrant of an 8x8
// input block, then replays it as an 8x8 block with every pixel doubled in both axes.
module avg_unpool #(
  parameter int WIDTH_IN  = 8,
  parameter int WIDTH_OUT = 4,
  parameter int PIX_W     = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [1:0]       sub_block,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [PIX_W-1:0] in_data,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [PIX_W-1:0] out_data,
  output logic             out_last,
  output logic             busy
);

  localparam int NPIX = WIDTH_IN * WIDTH_IN;
  localparam int NQ   = WIDTH_OUT * WIDTH_OUT;
  localparam logic [5:0] LAST_IDX = 6'(NPIX - 1);

  typedef enum logic {LOAD, EMIT} state_t;

  state_t           state, state_nxt;
  logic [5:0]       in_cnt, out_cnt;
  logic [1:0]       sel, sel_eff;
  logic [PIX_W-1:0] qbuf [NQ];
  logic             in_fire, out_fire, in_quad;
  logic [2:0]       row, col;
  logic [3:0]       wr_idx, rd_idx;

  assign in_ready  = (state == LOAD);
  assign out_valid = (state == EMIT);
  assign in_fire   = in_valid & in_ready;
  assign out_fire  = out_valid & out_ready;
  assign busy      = (state == EMIT) || (in_cnt != 6'd0);

  // The first beat of a block is checked against the quadrant it selects itself.
  assign sel_eff = (in_cnt == 6'd0) ? sub_block : sel;
  assign row     = in_cnt[5:3];
  assign col     = in_cnt[2:0];
  assign in_quad = (row[2] == sel_eff[1]) && (col[2] == sel_eff[0]);
  assign wr_idx  = {row[1:0], col[1:0]};

  // Output pixel (r,c) reads captured pixel (r/2, c/2).
  assign rd_idx   = {out_cnt[5:4], out_cnt[2:1]};
  assign out_data = qbuf[rd_idx];
  assign out_last = (state == EMIT) && (out_cnt == LAST_IDX);

  always_comb begin
    state_nxt = state;
    case (state)
      LOAD: if (in_fire && in_cnt == LAST_IDX) state_nxt = EMIT;
      EMIT: if (out_fire && out_cnt == LAST_IDX) state_nxt = LOAD;
      default: state_nxt = LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= LOAD;
      in_cnt  <= 6'd0;
      out_cnt <= 6'd0;
      sel     <= 2'd0;
    end else begin
      state <= state_nxt;
      if (in_fire) begin
        if (in_cnt == 6'd0) sel <= sub_block;
        in_cnt <= in_cnt + 6'd1;
      end
      if (out_fire) out_cnt <= out_cnt + 6'd1;
    end
  end

  // Pixel storage carries no reset; it is always fully rewritten before EMIT.
  always_ff @(posedge clk) begin
    if (in_fire && in_quad) qbuf[wr_idx] <= in_data;
  end

endmodule

// File: tb/tb_avg_unpool.sv
// Directed self-checking bench for avg_unpool: quadrant capture, replication,
// stalls, mid-block reset and back-to-back block timing.
module tb_avg_unpool;

  logic        clk;
  logic        rst_n;
  logic [1:0]  sub_block;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_data;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_data;
  logic        out_last;
  logic        busy;

  int          checks = 0;
  int          failures = 0;
  int          cyc = 0;
  int          start_cyc = 0;
  logic [31:0] got [64];

  avg_unpool #(.WIDTH_IN(8), .WIDTH_OUT(4), .PIX_W(32)) dut (
    .clk(clk), .rst_n(rst_n), .sub_block(sub_block),
    .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
    .out_last(out_last), .busy(busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checks++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got %0d, expected %0d", tag, observed, expected);
    end
  endtask

  function automatic logic [31:0] expPix(input logic [1:0] sb, input int base, input int i);
    int r, c;
    r = 4 * int'(sb[1]) + (i >> 4);
    c = 4 * int'(sb[0]) + ((i >> 1) & 3);
    return 32'(base + r * 8 + c);
  endfunction

  // Sends 64 beats; inputs driven on the falling edge, accepted on the next rising edge.
  task automatic applyStimulus(input logic [1:0] sb, input int base, input bit gaps, input bit toggle);
    int k = 0;
    int guard = 0;
    bit first = 1'b1;
    while (k < 64) begin
      @(negedge clk);
      if (first) checkOutput("in_ready_rise", in_ready, 1);
      first = 1'b0;
      checkOutput("load_out_valid", out_valid, 0);
      checkOutput("load_busy", busy, (k != 0));
      in_valid  = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
      in_data   = 32'(base + k);
      if (k == 0) sub_block = sb;
      else if (toggle) sub_block = sub_block + 2'd1;
      if (in_valid && in_ready) begin
        if (k == 0) start_cyc = cyc;
        k++;
      end
      guard++;
      if (guard > 2000) begin
        checkOutput("input_timeout", 1, 0);
        break;
      end
    end
  endtask

  // Collects up to 'limit' output pixels into got[], checking stability under stalls.
  task automatic collectOutput(input bit bp, input int limit);
    int n = 0;
    int guard = 0;
    bit first = 1'b1;
    bit stalled = 1'b0;
    logic [31:0] held_data = '0;
    logic held_last = 1'b0;
    while (n < limit) begin
      @(negedge clk);
      in_valid = 1'b0;
      if (first) begin
        checkOutput("latency_out_valid", out_valid, 1);
        checkOutput("emit_busy", busy, 1);
      end
      first = 1'b0;
      checkOutput("emit_in_ready", in_ready, 0);
      if (stalled) begin
        checkOutput("stall_data", out_data, held_data);
        checkOutput("stall_last", out_last, held_last);
      end
      out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      stalled = out_valid && !out_ready;
      held_data = out_data;
      held_last = out_last;
      if (out_valid && out_ready) begin
        got[n] = out_data;
        checkOutput("out_last", out_last, (n == 63));
        n++;
      end
      guard++;
      if (guard > 2000) begin
        checkOutput("output_timeout", 1, 0);
        break;
      end
    end
  endtask

  task automatic verifyBlock(input logic [1:0] sb, input int base);
    for (int i = 0; i < 64; i++) checkOutput("pixel", got[i], expPix(sb, base, i));
  endtask

  initial begin
    int s0, s1, s2;
    rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0; sub_block = 2'd0; in_data = '0;
    repeat (2) @(negedge clk);
    checkOutput("rst_in_ready", in_ready, 1);
    checkOutput("rst_out_valid", out_valid, 0);
    checkOutput("rst_out_last", out_last, 0);
    checkOutput("rst_busy", busy, 0);
    rst_n = 1'b1;

    $display("[TB] quadrant 0, ramp data");
    applyStimulus(2'd0, 0, 1'b0, 1'b0);
    collectOutput(1'b0, 64);
    checkOutput("q0_o0", got[0], 0);  checkOutput("q0_o1", got[1], 0);
    checkOutput("q0_o2", got[2], 1);  checkOutput("q0_o3", got[3], 1);
    checkOutput("q0_o4", got[4], 2);  checkOutput("q0_o5", got[5], 2);
    checkOutput("q0_o6", got[6], 3);  checkOutput("q0_o7", got[7], 3);
    checkOutput("q0_o8", got[8], 0);  checkOutput("q0_o9", got[9], 0);
    checkOutput("q0_o10", got[10], 1); checkOutput("q0_o11", got[11], 1);
    checkOutput("q0_o16", got[16], 8); checkOutput("q0_o63", got[63], 27);
    verifyBlock(2'd0, 0);

    $display("[TB] quadrants 3, 1, 2");
    applyStimulus(2'd3, 0, 1'b0, 1'b0);
    collectOutput(1'b0, 64);
    checkOutput("q3_o0", got[0], 36); checkOutput("q3_o1", got[1], 36);
    checkOutput("q3_o9", got[9], 36); checkOutput("q3_o2", got[2], 37);
    checkOutput("q3_o63", got[63], 63);
    verifyBlock(2'd3, 0);
    applyStimulus(2'd1, 0, 1'b0, 1'b0);
    collectOutput(1'b0, 64);
    checkOutput("q1_o0", got[0], 4); checkOutput("q1_o63", got[63], 31);
    verifyBlock(2'd1, 0);
    applyStimulus(2'd2, 0, 1'b0, 1'b0);
    collectOutput(1'b0, 64);
    checkOutput("q2_o0", got[0], 32); checkOutput("q2_o63", got[63], 59);
    verifyBlock(2'd2, 0);

    $display("[TB] sub_block toggling during load");
    applyStimulus(2'd2, 0, 1'b0, 1'b1);
    collectOutput(1'b0, 64);
    checkOutput("tog_o0", got[0], 32);
    verifyBlock(2'd2, 0);

    $display("[TB] input gaps and output backpressure");
    applyStimulus(2'd1, 500, 1'b1, 1'b0);
    collectOutput(1'b1, 64);
    checkOutput("bp_o0", got[0], 504);
    verifyBlock(2'd1, 500);

    $display("[TB] reset in the middle of output");
    applyStimulus(2'd0, 0, 1'b0, 1'b0);
    collectOutput(1'b0, 20);
    @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    checkOutput("midrst_out_valid", out_valid, 0);
    checkOutput("midrst_in_ready", in_ready, 1);
    checkOutput("midrst_busy", busy, 0);
    rst_n = 1'b1;
    applyStimulus(2'd0, 100, 1'b0, 1'b0);
    collectOutput(1'b0, 64);
    checkOutput("b2_o0", got[0], 100); checkOutput("b2_o63", got[63], 127);
    verifyBlock(2'd0, 100);

    $display("[TB] three back-to-back blocks");
    applyStimulus(2'd3, 1000, 1'b0, 1'b0);
    s0 = start_cyc;
    collectOutput(1'b0, 64);
    verifyBlock(2'd3, 1000);
    applyStimulus(2'd0, 2000, 1'b0, 1'b0);
    s1 = start_cyc;
    collectOutput(1'b0, 64);
    verifyBlock(2'd0, 2000);
    applyStimulus(2'd1, 3000, 1'b0, 1'b0);
    s2 = start_cyc;
    collectOutput(1'b0, 64);
    verifyBlock(2'd1, 3000);
    checkOutput("period_01", 64'(s1 - s0), 128);
    checkOutput("period_12", 64'(s2 - s1), 128);

    @(negedge clk);
    checkOutput("end_in_ready", in_ready, 1);
    checkOutput("end_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/avg_unpool.md
# avg_unpool

Streaming 2x nearest-neighbour unpooling stage, the inverse-direction partner of the 2x2 average-pool stage. It accepts one 8x8 block of 32-bit pixels in raster order and captures the 4x4 quadrant selected by `sub_block`. It then emits a full 8x8 block in raster order in which every captured pixel is replicated into a 2x2 patch. It sits on the read-back path between the DDR3 block fetch and the next convolution stage.

## Interface
- `WIDTH_IN`, 8, side length of the input and output block in pixels
- `WIDTH_OUT`, 4, side length of the captured quadrant; fixed at `WIDTH_IN/2`
- `PIX_W`, 32, pixel width in bits
- `clk` input 1: single clock; all logic is on its rising edge
- `rst_n` input 1: asynchronous, active-low reset
- `sub_block` input 2: quadrant select; sampled only on the first accepted beat of a block
- `in_valid` input 1: input pixel valid
- `in_ready` output 1: block can accept an input pixel
- `in_data` input `PIX_W`: input pixel, raster order, index k = row*`WIDTH_IN` + col
- `out_valid` output 1: output pixel valid
- `out_ready` input 1: downstream accepts the output pixel
- `out_data` output `PIX_W`: output pixel, raster order
- `out_last` output 1: high with the final (index 63) output pixel
- `busy` output 1: high in `EMIT`, or in `LOAD` with `in_cnt` != 0

## Operation
- Storage: `qbuf` holds 16 x `PIX_W` registers; `sel` holds 2 bits.
- Counters: `in_cnt` and `out_cnt`, both 6 bits.
- States: `LOAD` and `EMIT`. Reset enters `LOAD` with `in_cnt=0`, `out_cnt=0`, `sel=0`; `qbuf` is not reset.
- `LOAD` behaviour:
  - `in_ready=1`, `out_valid=0`.
  - A beat is accepted when `in_valid & in_ready`.
  - Accepted beat with `in_cnt==0`: latch `sel <= sub_block`. That beat is also quadrant-checked against the new `sel` value.
  - Quadrant origin: r0 = 4*sel[1], c0 = 4*sel[0]. An accepted beat at (row, col) = (k>>3, k&7) is stored when r0<=row<r0+4 and c0<=col<c0+4, at `qbuf[(row-r0)*4 + (col-c0)]`. All other beats are consumed and discarded.
  - Every accepted beat increments `in_cnt`. The beat accepted at `in_cnt==63` wraps `in_cnt` to 0 and moves the FSM to `EMIT`.
- `EMIT` behaviour:
  - `in_ready=0`, `out_valid=1`.
  - `out_data = qbuf[((out_cnt>>4)&3)*4 + ((out_cnt>>1)&3)]`, i.e. output (r,c) takes captured pixel (r/2, c/2).
  - `out_last = (out_cnt==63)`.
  - Each `out_valid & out_ready` increments `out_cnt`. The handshake at 63 wraps `out_cnt` to 0 and returns the FSM to `LOAD`.
- Pixel values are copied bit-exact; there is no arithmetic, rounding or saturation.
- `sub_block` changes in the middle of a block are ignored until the next block.
- Reset asserted mid-block: the current block is abandoned, both counters return to 0, and the FSM returns to `LOAD`. No partial output is emitted after reset.

## Timing
- Reset values: `in_ready=1`, `out_valid=0`, `out_last=0`, `busy=0`, `out_data` undefined until the first `EMIT`.
- Input throughput is 1 pixel/cycle; `in_valid` gaps only stall the block.
- Latency: `out_valid` rises on the cycle after the 64th input handshake. With `out_ready` held at 1, the output stream occupies 64 consecutive cycles.
- Minimum period is 128 cycles per block; input and output never overlap.
- Under backpressure (`out_valid & !out_ready`), `out_data` and `out_last` hold stable until the handshake.
- `in_ready` rises on the cycle after the `out_last` handshake.
- `out_data` is a combinational mux of `qbuf` registers indexed by the `out_cnt` register; it has no combinational path from any input port.

## Test plan
- Quadrant 0, `in_data`=k for k=0..63, `out_ready`=1 -> first outputs 0,0,1,1,2,2,3,3; out[8..11]=0,0,1,1; out[16]=8; out[63]=27 with `out_last`=1; `out_valid` first high exactly 1 cycle after the 64th input beat.
- Quadrant 3, same data -> out[0]=36, out[1]=36, out[9]=36, out[2]=37, out[63]=63; repeat with sub_block 1 (out[0]=4, out[63]=31) and sub_block 2 (out[0]=32, out[63]=59).
- `sub_block` toggled every cycle during `LOAD` -> output follows only the value present on beat 0.
- Random `in_valid` gaps and random `out_ready` deasserts -> identical 64-value output sequence; `out_data` stable through every stall; `in_ready`=0 throughout `EMIT`.
- `rst_n` pulsed low at output 20 of block 1, then a full block 2 sent with `in_data`=100+k, quadrant 0 -> no further block-1 outputs; block-2 out[0]=100, out[63]=127.
- Three back-to-back blocks -> `in_ready` rises the cycle after each `out_last` handshake; there are 128 cycles per block with full-rate handshakes.
